rs_alu: RTL and testbench
=========================

// Module: rs_alu
// PURPOSE
//  Reservation station for ALU/branch ops; sits between the decoder/dispatch stage and the execution unit.
//  Buffers dispatched ops, snoops the EX and LSB result broadcasts to wake waiting operands, and issues
//  at most one ready op per cycle to EX as a registered packet (op, pc, imm, vs1, vs2, qd).
// PARAMETERS
//  RS_SIZE    16  number of entries (power of 2, >=2)
//  OP_W       5   internal opcode width (same encoding EX decodes)
//  DAT_W      32  register/data width
//  ROB_ADD_W  4   ROB tag width
// PORTS
//  clk            in   1          clock, all state on posedge
//  rst            in   1          asynchronous, active-low reset
//  en             in   1          global stall; 0 = hold all state, no issue, no dispatch accept
//  iROB_Clr       in   1          mispredict flush
//  iDC_En         in   1          dispatch valid
//  iDC_Op         in   OP_W       opcode
//  iDC_Pc         in   DAT_W      instruction pc
//  iDC_Imm        in   DAT_W      immediate
//  iDC_Rs1Busy    in   1          1 = operand 1 waits on tag iDC_Qs1
//  iDC_Qs1        in   ROB_ADD_W  producer tag, operand 1
//  iDC_Vs1        in   DAT_W      operand 1 value (valid when not busy)
//  iDC_Rs2Busy    in   1          as above, operand 2
//  iDC_Qs2        in   ROB_ADD_W  producer tag, operand 2
//  iDC_Vs2        in   DAT_W      operand 2 value
//  iDC_Qd         in   ROB_ADD_W  destination ROB tag
//  oDC_Full       out  1          all RS_SIZE entries valid (combinational from entry valid bits)
//  iEX_En/Qd/Vd   in   1/ROB_ADD_W/DAT_W  EX result broadcast
//  iLSB_En/Qd/Vd  in   1/ROB_ADD_W/DAT_W  LSB load result broadcast
//  oEX_En         out  1          issue valid, registered, one-cycle pulse per op
//  oEX_Op/Pc/Imm/Vs1/Vs2/Qd  out  OP_W/DAT_W x4/ROB_ADD_W  issued packet, registered
// BEHAVIOUR
//  - Reset (rst=0, async): all entries invalid; oEX_En=0, all oEX_* data =0; oDC_Full=0.
//  - Priority per posedge: rst > iROB_Clr > en=0 (hold) > normal operation.
//  - iROB_Clr=1: invalidate all entries, drop same-cycle dispatch, oEX_En<=0, data regs <=0.
//  - Dispatch: iDC_En=1 & !oDC_Full & en writes to the lowest-index free entry. A dispatch while full
//    is ignored (dispatcher's error); an issue in the same cycle does not free space for it.
//  - Wakeup: each cycle, for every valid waiting operand, iEX_En & iEX_Qd==Qs (or iLSB_*) loads Vd and
//    clears busy. Incoming dispatch operands are checked against the same-cycle broadcasts before being
//    stored (no lost wakeup). If EX and LSB carry the same tag, EX value wins (must not occur legally).
//  - Ready: entry valid and both operands not busy. Wakeup in cycle N makes the entry ready at edge N+1.
//  - Issue: at posedge, lowest-index ready entry is copied into oEX_* with oEX_En<=1 and the entry freed;
//    no ready entry -> oEX_En<=0, data regs <=0. Base latency dispatch->oEX_En = 2 edges (stored at N,
//    issued at N+1).
//  - Same entry may be freed by issue and rewritten by dispatch in one cycle only when not full.
//  - en=0: no state change; oEX_En holds its value (EX also stalled and ignores it).
//  - Tags compare on full ROB_ADD_W bits; no wrap logic needed (ROB guarantees tag uniqueness in flight).
// CONFIGURATION
//  RS_ISSUE_BYPASS_EN defined: if no stored entry is ready and the incoming dispatch is ready (after
//    same-cycle wakeup), it is issued directly at that edge and never occupies an entry (latency 1 edge).
//    Stored ready entries always take priority over the bypass.
//  Undefined: every dispatch is stored first; minimum dispatch->issue latency 2 edges.
// TESTING
//  1 Reset mid-run with 3 valid entries, rst low between edges -> oEX_En=0 and oDC_Full=0 immediately.
//  2 Dispatch ADD, Vs1=5, Vs2=7, Qd=3, no busy -> oEX_En=1 next edge (bypass) or edge after (no bypass),
//    oEX_Vs1=5, oEX_Vs2=7, oEX_Qd=3.
//  3 Dispatch op with Rs1Busy, Qs1=2; two cycles later iEX_En=1, Qd=2, Vd=0x10 -> issued one edge later
//    with oEX_Vs1=0x10.
//  4 Dispatch with Qs2=6 in the same cycle iLSB_En=1, Qd=6, Vd=0xAB -> issued with oEX_Vs2=0xAB, no hang.
//  5 Fill 16 waiting entries -> oDC_Full=1, 17th dispatch ignored; wake entries 4 and 9 together ->
//    entry 4 issues first, then 9; oDC_Full drops after first issue.
//  6 8 entries waiting, iROB_Clr=1 with concurrent dispatch -> all freed, oEX_En=0, later broadcast of
//    old tags issues nothing.

Source files
------------

// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch, result-broadcast and issue signals of the ALU reservation station.
// master = dispatch/broadcast side (drives requests, sees issue); slave = the station itself.
interface rs_alu_if #(
   parameter int OP_W      = 5,
   parameter int DAT_W     = 32,
   parameter int ROB_ADD_W = 4
) ();
   // dispatch
   logic                 iDC_En;
   logic [OP_W-1:0]      iDC_Op;
   logic [DAT_W-1:0]     iDC_Pc;
   logic [DAT_W-1:0]     iDC_Imm;
   logic                 iDC_Rs1Busy;
   logic [ROB_ADD_W-1:0] iDC_Qs1;
   logic [DAT_W-1:0]     iDC_Vs1;
   logic                 iDC_Rs2Busy;
   logic [ROB_ADD_W-1:0] iDC_Qs2;
   logic [DAT_W-1:0]     iDC_Vs2;
   logic [ROB_ADD_W-1:0] iDC_Qd;
   logic                 oDC_Full;
   // result broadcasts
   logic                 iEX_En;
   logic [ROB_ADD_W-1:0] iEX_Qd;
   logic [DAT_W-1:0]     iEX_Vd;
   logic                 iLSB_En;
   logic [ROB_ADD_W-1:0] iLSB_Qd;
   logic [DAT_W-1:0]     iLSB_Vd;
   // issue packet
   logic                 oEX_En;
   logic [OP_W-1:0]      oEX_Op;
   logic [DAT_W-1:0]     oEX_Pc;
   logic [DAT_W-1:0]     oEX_Imm;
   logic [DAT_W-1:0]     oEX_Vs1;
   logic [DAT_W-1:0]     oEX_Vs2;
   logic [ROB_ADD_W-1:0] oEX_Qd;

   modport master (
      output iDC_En, iDC_Op, iDC_Pc, iDC_Imm, iDC_Rs1Busy, iDC_Qs1, iDC_Vs1,
             iDC_Rs2Busy, iDC_Qs2, iDC_Vs2, iDC_Qd,
             iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
      input  oDC_Full, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
   );

   modport slave (
      input  iDC_En, iDC_Op, iDC_Pc, iDC_Imm, iDC_Rs1Busy, iDC_Qs1, iDC_Vs1,
             iDC_Rs2Busy, iDC_Qs2, iDC_Vs2, iDC_Qd,
             iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
      output oDC_Full, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
   );
endinterface

// File: rtl/rs_alu.sv
// rs_alu: reservation station for ALU/branch ops.
// Buffers dispatched ops, wakes waiting operands from the EX and LSB result broadcasts and
// issues the lowest-index ready entry as a registered packet, at most one per cycle.
// Optional feature macro: RS_ISSUE_BYPASS_EN -- a ready dispatch issues at its own edge when
// no stored entry is ready (stored entries always win).
module rs_alu #(
   parameter int RS_SIZE   = 16,
   parameter int OP_W      = 5,
   parameter int DAT_W     = 32,
   parameter int ROB_ADD_W = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    en,
   input  logic    iROB_Clr,
   rs_alu_if.slave bus
);
   localparam int IDX_W = $clog2(RS_SIZE);

   // entry storage
   logic [RS_SIZE-1:0]   r_vld;
   logic [RS_SIZE-1:0]   r_b1;
   logic [RS_SIZE-1:0]   r_b2;
   logic [OP_W-1:0]      r_op  [RS_SIZE];
   logic [DAT_W-1:0]     r_pc  [RS_SIZE];
   logic [DAT_W-1:0]     r_imm [RS_SIZE];
   logic [ROB_ADD_W-1:0] r_q1  [RS_SIZE];
   logic [DAT_W-1:0]     r_v1  [RS_SIZE];
   logic [ROB_ADD_W-1:0] r_q2  [RS_SIZE];
   logic [DAT_W-1:0]     r_v2  [RS_SIZE];
   logic [ROB_ADD_W-1:0] r_qd  [RS_SIZE];

   // issue packet registers
   logic                 r_ex_en;
   logic [OP_W-1:0]      r_ex_op;
   logic [DAT_W-1:0]     r_ex_pc;
   logic [DAT_W-1:0]     r_ex_imm;
   logic [DAT_W-1:0]     r_ex_vs1;
   logic [DAT_W-1:0]     r_ex_vs2;
   logic [ROB_ADD_W-1:0] r_ex_qd;

   // entry next state
   logic [RS_SIZE-1:0]   w_vld_n;
   logic [RS_SIZE-1:0]   w_b1_n;
   logic [RS_SIZE-1:0]   w_b2_n;
   logic [OP_W-1:0]      w_op_n  [RS_SIZE];
   logic [DAT_W-1:0]     w_pc_n  [RS_SIZE];
   logic [DAT_W-1:0]     w_imm_n [RS_SIZE];
   logic [ROB_ADD_W-1:0] w_q1_n  [RS_SIZE];
   logic [DAT_W-1:0]     w_v1_n  [RS_SIZE];
   logic [ROB_ADD_W-1:0] w_q2_n  [RS_SIZE];
   logic [DAT_W-1:0]     w_v2_n  [RS_SIZE];
   logic [ROB_ADD_W-1:0] w_qd_n  [RS_SIZE];

   // issue packet next state
   logic                 w_ex_en_n;
   logic [OP_W-1:0]      w_ex_op_n;
   logic [DAT_W-1:0]     w_ex_pc_n;
   logic [DAT_W-1:0]     w_ex_imm_n;
   logic [DAT_W-1:0]     w_ex_vs1_n;
   logic [DAT_W-1:0]     w_ex_vs2_n;
   logic [ROB_ADD_W-1:0] w_ex_qd_n;

   // selection
   logic                 w_full;
   logic [RS_SIZE-1:0]   w_rdy;
   logic                 w_iss_any;
   logic [RS_SIZE-1:0]   w_iss_oh;
   logic [IDX_W-1:0]     w_iss_idx;
   logic [RS_SIZE-1:0]   w_avail;
   logic [RS_SIZE-1:0]   w_free_oh;
   logic [RS_SIZE-1:0]   w_sel;

   // incoming dispatch after same-cycle wakeup
   logic                 w_in_b1;
   logic [DAT_W-1:0]     w_in_v1;
   logic                 w_in_b2;
   logic [DAT_W-1:0]     w_in_v2;
   logic                 w_dc_acc;
   logic                 w_byp;
   logic                 w_dc_wr;

   // Operand wakeup: returns {busy, value}; EX beats LSB if both carry the tag.
   function automatic logic [DAT_W:0] f_wake(
      input logic                 busy,
      input logic [ROB_ADD_W-1:0] q,
      input logic [DAT_W-1:0]     v,
      input logic                 ex_en,
      input logic [ROB_ADD_W-1:0] ex_qd,
      input logic [DAT_W-1:0]     ex_vd,
      input logic                 lsb_en,
      input logic [ROB_ADD_W-1:0] lsb_qd,
      input logic [DAT_W-1:0]     lsb_vd
   );
      logic [DAT_W:0] res;
      if (busy && ex_en && (ex_qd == q)) begin
         res = {1'b0, ex_vd};
      end else if (busy && lsb_en && (lsb_qd == q)) begin
         res = {1'b0, lsb_vd};
      end else begin
         res = {busy, v};
      end
      return res;
   endfunction

   // Ready vector, lowest ready entry and lowest slot available for dispatch.
   always_comb begin
      w_full    = &r_vld;
      w_rdy     = r_vld & ~r_b1 & ~r_b2;
      w_iss_any = |w_rdy;
      w_iss_oh  = w_rdy & (~w_rdy + RS_SIZE'(1));
      w_iss_idx = {IDX_W{1'b0}};
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         w_iss_idx = w_rdy[i] ? IDX_W'(i) : w_iss_idx;
      end
      // the entry issuing this edge may be reused only when the station is not full
      w_avail   = ~r_vld | (w_full ? {RS_SIZE{1'b0}} : w_iss_oh);
      w_free_oh = w_avail & (~w_avail + RS_SIZE'(1));
   end

   // Incoming operands see same-cycle broadcasts; decide store vs. bypass.
   always_comb begin
      {w_in_b1, w_in_v1} = f_wake(bus.iDC_Rs1Busy, bus.iDC_Qs1, bus.iDC_Vs1,
                                  bus.iEX_En, bus.iEX_Qd, bus.iEX_Vd,
                                  bus.iLSB_En, bus.iLSB_Qd, bus.iLSB_Vd);
      {w_in_b2, w_in_v2} = f_wake(bus.iDC_Rs2Busy, bus.iDC_Qs2, bus.iDC_Vs2,
                                  bus.iEX_En, bus.iEX_Qd, bus.iEX_Vd,
                                  bus.iLSB_En, bus.iLSB_Qd, bus.iLSB_Vd);
      w_dc_acc = bus.iDC_En & ~w_full;
`ifdef RS_ISSUE_BYPASS_EN
      w_byp    = w_dc_acc & ~w_iss_any & ~w_in_b1 & ~w_in_b2;
`else
      w_byp    = 1'b0;
`endif
      w_dc_wr  = w_dc_acc & ~w_byp;
      w_sel    = w_dc_wr ? w_free_oh : {RS_SIZE{1'b0}};
   end

   // Entry next state: dispatch write into the selected slot, otherwise wakeup and issue release.
   always_comb begin
      w_vld_n = r_vld;
      w_b1_n  = r_b1;
      w_b2_n  = r_b2;
      w_op_n  = r_op;
      w_pc_n  = r_pc;
      w_imm_n = r_imm;
      w_q1_n  = r_q1;
      w_v1_n  = r_v1;
      w_q2_n  = r_q2;
      w_v2_n  = r_v2;
      w_qd_n  = r_qd;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (w_sel[i]) begin
            w_vld_n[i] = 1'b1;
            w_op_n[i]  = bus.iDC_Op;
            w_pc_n[i]  = bus.iDC_Pc;
            w_imm_n[i] = bus.iDC_Imm;
            w_b1_n[i]  = w_in_b1;
            w_q1_n[i]  = bus.iDC_Qs1;
            w_v1_n[i]  = w_in_v1;
            w_b2_n[i]  = w_in_b2;
            w_q2_n[i]  = bus.iDC_Qs2;
            w_v2_n[i]  = w_in_v2;
            w_qd_n[i]  = bus.iDC_Qd;
         end else begin
            w_vld_n[i] = r_vld[i] & ~w_iss_oh[i];
            {w_b1_n[i], w_v1_n[i]} = f_wake(r_b1[i], r_q1[i], r_v1[i],
                                            bus.iEX_En, bus.iEX_Qd, bus.iEX_Vd,
                                            bus.iLSB_En, bus.iLSB_Qd, bus.iLSB_Vd);
            {w_b2_n[i], w_v2_n[i]} = f_wake(r_b2[i], r_q2[i], r_v2[i],
                                            bus.iEX_En, bus.iEX_Qd, bus.iEX_Vd,
                                            bus.iLSB_En, bus.iLSB_Qd, bus.iLSB_Vd);
         end
      end
   end

   // Issue packet: lowest ready stored entry, else bypassed dispatch, else an empty packet.
   always_comb begin
      if (w_iss_any) begin
         w_ex_en_n  = 1'b1;
         w_ex_op_n  = r_op[w_iss_idx];
         w_ex_pc_n  = r_pc[w_iss_idx];
         w_ex_imm_n = r_imm[w_iss_idx];
         w_ex_vs1_n = r_v1[w_iss_idx];
         w_ex_vs2_n = r_v2[w_iss_idx];
         w_ex_qd_n  = r_qd[w_iss_idx];
      end else if (w_byp) begin
         w_ex_en_n  = 1'b1;
         w_ex_op_n  = bus.iDC_Op;
         w_ex_pc_n  = bus.iDC_Pc;
         w_ex_imm_n = bus.iDC_Imm;
         w_ex_vs1_n = w_in_v1;
         w_ex_vs2_n = w_in_v2;
         w_ex_qd_n  = bus.iDC_Qd;
      end else begin
         w_ex_en_n  = 1'b0;
         w_ex_op_n  = {OP_W{1'b0}};
         w_ex_pc_n  = {DAT_W{1'b0}};
         w_ex_imm_n = {DAT_W{1'b0}};
         w_ex_vs1_n = {DAT_W{1'b0}};
         w_ex_vs2_n = {DAT_W{1'b0}};
         w_ex_qd_n  = {ROB_ADD_W{1'b0}};
      end
   end

   // State update: reset, then flush, then stall-hold, then normal operation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld    <= {RS_SIZE{1'b0}};
         r_b1     <= {RS_SIZE{1'b0}};
         r_b2     <= {RS_SIZE{1'b0}};
         for (int i = 0; i < RS_SIZE; i++) begin
            r_op[i]  <= {OP_W{1'b0}};
            r_pc[i]  <= {DAT_W{1'b0}};
            r_imm[i] <= {DAT_W{1'b0}};
            r_q1[i]  <= {ROB_ADD_W{1'b0}};
            r_v1[i]  <= {DAT_W{1'b0}};
            r_q2[i]  <= {ROB_ADD_W{1'b0}};
            r_v2[i]  <= {DAT_W{1'b0}};
            r_qd[i]  <= {ROB_ADD_W{1'b0}};
         end
         r_ex_en  <= 1'b0;
         r_ex_op  <= {OP_W{1'b0}};
         r_ex_pc  <= {DAT_W{1'b0}};
         r_ex_imm <= {DAT_W{1'b0}};
         r_ex_vs1 <= {DAT_W{1'b0}};
         r_ex_vs2 <= {DAT_W{1'b0}};
         r_ex_qd  <= {ROB_ADD_W{1'b0}};
      end else if (iROB_Clr) begin
         r_vld    <= {RS_SIZE{1'b0}};
         r_b1     <= {RS_SIZE{1'b0}};
         r_b2     <= {RS_SIZE{1'b0}};
         r_ex_en  <= 1'b0;
         r_ex_op  <= {OP_W{1'b0}};
         r_ex_pc  <= {DAT_W{1'b0}};
         r_ex_imm <= {DAT_W{1'b0}};
         r_ex_vs1 <= {DAT_W{1'b0}};
         r_ex_vs2 <= {DAT_W{1'b0}};
         r_ex_qd  <= {ROB_ADD_W{1'b0}};
      end else if (en) begin
         r_vld    <= w_vld_n;
         r_b1     <= w_b1_n;
         r_b2     <= w_b2_n;
         r_op     <= w_op_n;
         r_pc     <= w_pc_n;
         r_imm    <= w_imm_n;
         r_q1     <= w_q1_n;
         r_v1     <= w_v1_n;
         r_q2     <= w_q2_n;
         r_v2     <= w_v2_n;
         r_qd     <= w_qd_n;
         r_ex_en  <= w_ex_en_n;
         r_ex_op  <= w_ex_op_n;
         r_ex_pc  <= w_ex_pc_n;
         r_ex_imm <= w_ex_imm_n;
         r_ex_vs1 <= w_ex_vs1_n;
         r_ex_vs2 <= w_ex_vs2_n;
         r_ex_qd  <= w_ex_qd_n;
      end
   end

   assign bus.oDC_Full = w_full;
   assign bus.oEX_En   = r_ex_en;
   assign bus.oEX_Op   = r_ex_op;
   assign bus.oEX_Pc   = r_ex_pc;
   assign bus.oEX_Imm  = r_ex_imm;
   assign bus.oEX_Vs1  = r_ex_vs1;
   assign bus.oEX_Vs2  = r_ex_vs2;
   assign bus.oEX_Qd   = r_ex_qd;
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed stimulus for rs_alu with a scoreboard of expected issue packets.
module tb_rs_alu;
   localparam int OP_W = 5;
   localparam int DAT_W = 32;
   localparam int RA = 4;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [DAT_W-1:0] pc;
      logic [DAT_W-1:0] imm;
      logic [DAT_W-1:0] vs1;
      logic [DAT_W-1:0] vs2;
      logic [RA-1:0]    qd;
   } pkt_t;

   logic clk;
   logic rst;
   logic en;
   logic clr;
   logic edge_en;
   pkt_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   rs_alu_if #(.OP_W(OP_W), .DAT_W(DAT_W), .ROB_ADD_W(RA)) bus ();

   rs_alu #(.RS_SIZE(16), .OP_W(OP_W), .DAT_W(DAT_W), .ROB_ADD_W(RA)) dut (
      .clk(clk), .rst(rst), .en(en), .iROB_Clr(clr), .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // an issue is new only if the DUT was enabled at the edge that produced it
   always @(posedge clk) edge_en <= en;

   // Monitor: every new issue packet is popped from the scoreboard and compared.
   always @(negedge clk) begin
      pkt_t a;
      pkt_t e;
      if (rst && bus.oEX_En && edge_en) begin
         a = {bus.oEX_Op, bus.oEX_Pc, bus.oEX_Imm, bus.oEX_Vs1, bus.oEX_Vs2, bus.oEX_Qd};
         n_chk++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL issue_unexpected: got op=%0h pc=%0h qd=%0h, required no issue",
                     a.op, a.pc, a.qd);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               n_err++;
               $display("FAIL issue_pkt: got op=%0h pc=%0h imm=%0h vs1=%0h vs2=%0h qd=%0h, required op=%0h pc=%0h imm=%0h vs1=%0h vs2=%0h qd=%0h",
                        a.op, a.pc, a.imm, a.vs1, a.vs2, a.qd, e.op, e.pc, e.imm, e.vs1, e.vs2, e.qd);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic push(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] vs1, input logic [31:0] vs2, input logic [3:0] qd);
      pkt_t p;
      p.op = op; p.pc = pc; p.imm = imm; p.vs1 = vs1; p.vs2 = vs2; p.qd = qd;
      exp_q.push_back(p);
   endtask

   task automatic dispatch(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                           input logic b1, input logic [3:0] q1, input logic [31:0] v1,
                           input logic b2, input logic [3:0] q2, input logic [31:0] v2,
                           input logic [3:0] qd);
      bus.iDC_En = 1'b1; bus.iDC_Op = op; bus.iDC_Pc = pc; bus.iDC_Imm = imm;
      bus.iDC_Rs1Busy = b1; bus.iDC_Qs1 = q1; bus.iDC_Vs1 = v1;
      bus.iDC_Rs2Busy = b2; bus.iDC_Qs2 = q2; bus.iDC_Vs2 = v2; bus.iDC_Qd = qd;
      tick();
      bus.iDC_En = 1'b0; bus.iDC_Rs1Busy = 1'b0; bus.iDC_Rs2Busy = 1'b0;
   endtask

   task automatic bcast_ex(input logic [3:0] q, input logic [31:0] v);
      bus.iEX_En = 1'b1; bus.iEX_Qd = q; bus.iEX_Vd = v;
      tick();
      bus.iEX_En = 1'b0;
   endtask

   initial begin
      logic byp;
`ifdef RS_ISSUE_BYPASS_EN
      byp = 1'b1;
`else
      byp = 1'b0;
`endif
      rst = 1'b0; en = 1'b1; clr = 1'b0;
      bus.iDC_En = 1'b0; bus.iDC_Op = 5'd0; bus.iDC_Pc = 32'd0; bus.iDC_Imm = 32'd0;
      bus.iDC_Rs1Busy = 1'b0; bus.iDC_Qs1 = 4'd0; bus.iDC_Vs1 = 32'd0;
      bus.iDC_Rs2Busy = 1'b0; bus.iDC_Qs2 = 4'd0; bus.iDC_Vs2 = 32'd0; bus.iDC_Qd = 4'd0;
      bus.iEX_En = 1'b0; bus.iEX_Qd = 4'd0; bus.iEX_Vd = 32'd0;
      bus.iLSB_En = 1'b0; bus.iLSB_Qd = 4'd0; bus.iLSB_Vd = 32'd0;
      #2;
      check("reset_ex_en", 64'(bus.oEX_En), 64'd0);
      check("reset_full", 64'(bus.oDC_Full), 64'd0);
      check("reset_ex_pc", 64'(bus.oEX_Pc), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // 1: three waiting entries, asynchronous reset between edges, old tags then wake nothing
      for (int i = 1; i <= 3; i++) dispatch(5'd1, 32'h50 + 32'(i), 32'd0, 1'b1, 4'(i), 32'd0,
                                            1'b0, 4'd0, 32'd0, 4'(8 + i));
      rst = 1'b0;
      #1;
      check("midreset_ex_en", 64'(bus.oEX_En), 64'd0);
      check("midreset_full", 64'(bus.oDC_Full), 64'd0);
      tick();
      rst = 1'b1;
      for (int i = 1; i <= 3; i++) bcast_ex(4'(i), 32'h77);
      idle(3);

      // 2: ready ADD, latency 2 edges (1 with bypass)
      push(5'd1, 32'h100, 32'h0, 32'd5, 32'd7, 4'd3);
      dispatch(5'd1, 32'h100, 32'h0, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
      @(negedge clk);
      check("latency_first_edge", 64'(bus.oEX_En), 64'(byp));
      idle(4);

      // 3: operand 1 waits on tag 2, woken by EX two cycles later
      push(5'd2, 32'h200, 32'h4, 32'h10, 32'd1, 4'd4);
      dispatch(5'd2, 32'h200, 32'h4, 1'b1, 4'd2, 32'hFFFF, 1'b0, 4'd0, 32'd1, 4'd4);
      tick();
      bcast_ex(4'd2, 32'h10);
      idle(4);

      // 4: operand 2 woken by LSB in the dispatch cycle itself
      push(5'd3, 32'h300, 32'h8, 32'd9, 32'hAB, 4'd5);
      bus.iLSB_En = 1'b1; bus.iLSB_Qd = 4'd6; bus.iLSB_Vd = 32'hAB;
      dispatch(5'd3, 32'h300, 32'h8, 1'b0, 4'd0, 32'd9, 1'b1, 4'd6, 32'h55, 4'd5);
      bus.iLSB_En = 1'b0;
      idle(4);

      // 5: fill all 16, 17th ignored, wake 4 (EX) and 9 (LSB) together
      for (int i = 0; i < 16; i++) dispatch(5'd4, 32'h1000 + 32'(i), 32'h40 + 32'(i), 1'b1, 4'(i),
                                            32'd0, 1'b0, 4'd0, 32'(i), 4'(i));
      @(negedge clk);
      check("full_after_16", 64'(bus.oDC_Full), 64'd1);
      dispatch(5'd5, 32'hDEAD, 32'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd15);
      @(negedge clk);
      check("full_after_17th", 64'(bus.oDC_Full), 64'd1);
      push(5'd4, 32'h1004, 32'h44, 32'h44, 32'd4, 4'd4);
      push(5'd4, 32'h1009, 32'h49, 32'h99, 32'd9, 4'd9);
      bus.iEX_En = 1'b1; bus.iEX_Qd = 4'd4; bus.iEX_Vd = 32'h44;
      bus.iLSB_En = 1'b1; bus.iLSB_Qd = 4'd9; bus.iLSB_Vd = 32'h99;
      tick();
      bus.iEX_En = 1'b0; bus.iLSB_En = 1'b0;
      @(negedge clk);
      check("full_at_wake_edge", 64'(bus.oDC_Full), 64'd1);
      tick();
      @(negedge clk);
      check("full_after_first_issue", 64'(bus.oDC_Full), 64'd0);
      idle(4);

      // 6: flush leftovers; 8 waiting + 1 ready, flush with concurrent dispatch, old tags dead
      clr = 1'b1;
      tick();
      clr = 1'b0;
      @(negedge clk);
      check("full_after_flush", 64'(bus.oDC_Full), 64'd0);
      for (int i = 0; i < 8; i++) dispatch(5'd6, 32'h2000 + 32'(i), 32'd0, 1'b1, 4'(i), 32'd0,
                                           1'b0, 4'd0, 32'd0, 4'(i));
      if (byp) push(5'd7, 32'h700, 32'd0, 32'd3, 32'd4, 4'd12);
      dispatch(5'd7, 32'h700, 32'd0, 1'b0, 4'd0, 32'd3, 1'b0, 4'd0, 32'd4, 4'd12);
      clr = 1'b1;
      dispatch(5'd8, 32'hBAD, 32'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd13);
      clr = 1'b0;
      @(negedge clk);
      check("flush_ex_en", 64'(bus.oEX_En), 64'd0);
      check("flush_full", 64'(bus.oDC_Full), 64'd0);
      for (int i = 0; i < 8; i++) bcast_ex(4'(i), 32'h5A);
      idle(4);

      // stall: dispatch ignored while en=0; stored op held until en returns
      en = 1'b0;
      dispatch(5'd9, 32'h800, 32'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd1);
      en = 1'b1;
      idle(4);
      push(5'd10, 32'h900, 32'h1, 32'h21, 32'h22, 4'd2);
      dispatch(5'd10, 32'h900, 32'h1, 1'b0, 4'd0, 32'h21, 1'b0, 4'd0, 32'h22, 4'd2);
      en = 1'b0;
      idle(3);
      @(negedge clk);
      check("stall_hold_ex_en", 64'(bus.oEX_En), 64'(byp));
      en = 1'b1;
      idle(4);

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
